// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU controller and MDU.
// ALU codes, alu_op classes, funct values and MDU state/op enums.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] AOP_MEM   = 2'b00;
  localparam logic [1:0] AOP_BR    = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mdu_state_t;

  typedef enum logic [1:0] {
    MDU_MULT,
    MDU_MULTU,
    MDU_DIV,
    MDU_DIVU
  } mdu_op_t;

endpackage

// File: rtl/mdu_core.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// Divider datapath present only when MDU_DIV_EN is defined.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH-1:0] mcand;
  logic             neg_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

`ifdef MDU_DIV_EN
  logic             is_div;
  logic             neg_r;
  logic             div0;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  logic             ge;
  logic             op_div;
  assign op_div = (op == MDU_DIV) || (op == MDU_DIVU);
  assign sgn = (op == MDU_MULT) || (op == MDU_DIV);
`else
  assign sgn = (op == MDU_MULT);
`endif

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration step and the final sign correction.
  always_comb begin
    mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
    prod    = {p_hi, p_lo};
    if (neg_q) prod = -prod;
    res_hi  = prod[2*WIDTH-1:WIDTH];
    res_lo  = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    r_sh  = {p_hi, p_lo[WIDTH-1]};
    r_sub = r_sh - {1'b0, mcand};
    ge    = (r_sh >= {1'b0, mcand});
    if (is_div) begin
      step_hi = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
      step_lo = {p_lo[WIDTH-2:0], ge};
      res_hi  = neg_r ? -p_hi : p_hi;
      res_lo  = div0 ? '1 : (neg_q ? -p_lo : p_lo);
    end
`endif
  end

  // MDU sequencer: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      mcand <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            p_hi  <= '0;
            neg_q <= a_neg ^ b_neg;
            p_lo  <= b_mag;
            mcand <= a_mag;
`ifdef MDU_DIV_EN
            is_div <= op_div;
            neg_r  <= a_neg;
            div0   <= (b == '0);
            if (op_div) begin
              p_lo  <= a_mag;
              mcand <= b_mag;
            end
`endif
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        RUN: begin
          p_hi <= step_hi;
          p_lo <= step_lo;
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU control decode, MDU stall and HI/LO read mux.
// Define MDU_DIV_EN to include div/divu support.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              mdu_sel,
  output logic [WIDTH-1:0]  mdu_rdata,
  output logic              stall,
  output logic              mdu_busy,
  output logic              illegal
);

  logic       is_mdu;
  logic       is_start;
  logic       d_wr_hi;
  logic       d_wr_lo;
  logic       rd_hi;
  logic       rd_lo;
  mdu_op_t    mop;
  logic [3:0] code;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic       start;
  logic       wr_ok;

  // Decode alu_op/funct into ALU code and MDU request class.
  always_comb begin
    code     = ALU_AND;
    illegal  = 1'b0;
    is_mdu   = 1'b0;
    is_start = 1'b0;
    d_wr_hi  = 1'b0;
    d_wr_lo  = 1'b0;
    rd_hi    = 1'b0;
    rd_lo    = 1'b0;
    mop      = MDU_MULT;
    unique case (alu_op)
      AOP_MEM: code = ALU_ADD;
      AOP_BR:  code = ALU_SUB;
      AOP_RTYPE: begin
        unique case (funct)
          F_ADD, F_ADDU: code = ALU_ADD;
          F_SUB, F_SUBU: code = ALU_SUB;
          F_AND:  code = ALU_AND;
          F_OR:   code = ALU_OR;
          F_XOR:  code = ALU_XOR;
          F_NOR:  code = ALU_NOR;
          F_SLT:  code = ALU_SLT;
          F_SLTU: code = ALU_SLTU;
          F_SLL:  code = ALU_SLL;
          F_SRL:  code = ALU_SRL;
          F_SRA:  code = ALU_SRA;
          F_MULT: begin
            is_mdu   = 1'b1;
            is_start = 1'b1;
            mop      = MDU_MULT;
          end
          F_MULTU: begin
            is_mdu   = 1'b1;
            is_start = 1'b1;
            mop      = MDU_MULTU;
          end
`ifdef MDU_DIV_EN
          F_DIV: begin
            is_mdu   = 1'b1;
            is_start = 1'b1;
            mop      = MDU_DIV;
          end
          F_DIVU: begin
            is_mdu   = 1'b1;
            is_start = 1'b1;
            mop      = MDU_DIVU;
          end
`endif
          F_MFHI: begin
            is_mdu = 1'b1;
            rd_hi  = 1'b1;
          end
          F_MTHI: begin
            is_mdu  = 1'b1;
            d_wr_hi = 1'b1;
          end
          F_MFLO: begin
            is_mdu = 1'b1;
            rd_lo  = 1'b1;
          end
          F_MTLO: begin
            is_mdu  = 1'b1;
            d_wr_lo = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctrl  = CTRL_W'(code);
  assign mdu_sel   = rd_hi | rd_lo;
  assign mdu_rdata = rd_hi ? hi : (rd_lo ? lo : '0);
  assign stall     = valid_in & mdu_busy & is_mdu;
  assign wr_ok     = valid_in & ~mdu_busy & ~flush;
  assign start     = wr_ok & is_start;

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (start),
    .op    (mop),
    .wr_hi (wr_ok & d_wr_hi),
    .wr_lo (wr_ok & d_wr_lo),
    .a     (rs_val),
    .b     (rt_val),
    .hi    (hi),
    .lo    (lo),
    .busy  (mdu_busy)
  );

endmodule
